// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: state encoding and datapath mux select codes for the multicycle controller
package arm_mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, LINK
    } state_t;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_PC     = 2'b11;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
endpackage

// File: rtl/mc_write_gate.sv
// mc_write_gate: condition/NoWrite/R15 gating of raw write strobes into architectural write enables
module mc_write_gate (
    input  logic       en,
    input  logic       reg_w,
    input  logic       dp,
    input  logic       mem_w,
    input  logic       branch,
    input  logic       next_pc,
    input  logic       cond_ex,
    input  logic       no_write,
    input  logic [3:0] wa,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);
    assign reg_write = en & reg_w & cond_ex & !(dp & no_write);
    assign mem_write = en & mem_w & cond_ex;
    // a register write landing on R15 is a jump
    assign pc_write  = en & (next_pc | (branch & cond_ex) | (reg_write & (wa == 4'd15)));
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM sequencing the shared datapath of the multicycle ARM core
// Optional BL support enabled by defining BRANCH_LINK_EN.
module multicycle_controller
    import arm_mc_pkg::*;
#(
    parameter int         STATE_W  = 4,
    parameter logic [3:0] LINK_REG = 4'd14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               CondEx,
    input  logic               NoWrite,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               FlagEn,
    output logic               link_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);
    state_t state, nxt;
    logic bl, exec, unused;
`ifdef BRANCH_LINK_EN
    assign bl     = Funct[4];
    assign link_o = !reset & (state == LINK);
`else
    assign bl     = 1'b0;
    assign link_o = 1'b0;
`endif
    assign unused = ^Funct[4:1];
    always_ff @(posedge clk)
        state <= reset ? FETCH : nxt;
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:        nxt = mem_ready ? DECODE : FETCH;
            DECODE:       nxt = Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                                Op == 2'b01 ? MEMADR :
                                Op == 2'b10 ? (bl ? LINK : BRANCH) : FETCH;
            MEMADR:       nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:        nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:        nxt = mem_ready ? FETCH : MEMWR;
            EXECR, EXECI: nxt = ALUWB;
            LINK:         nxt = BRANCH;
            default:      nxt = FETCH;
        endcase
    end
    assign exec      = (state == EXECR) | (state == EXECI);
    assign state_o   = STATE_W'(state);
    assign IRWrite   = !reset & (state == FETCH) & mem_ready;
    assign AdrSrc    = (state == MEMRD) | (state == MEMWR);
    assign ALUSrcA   = (state == FETCH) | (state == DECODE);
    assign ALUOp     = exec;
    assign FlagEn    = !reset & exec & CondEx;
    assign illegal_o = !reset & (state == DECODE) & (Op == 2'b11);
    always_comb begin
        ALUSrcB   = ALUSrcA ? SRCB_FOUR :
                    (state == EXECI || state == MEMADR || state == BRANCH) ? SRCB_IMM : SRCB_REG;
        ResultSrc = (ALUSrcA || state == BRANCH) ? RES_ALURES :
                    state == MEMWB ? RES_RDATA :
                    state == LINK ? RES_PC : RES_ALUOUT;
    end
    mc_write_gate u_gate (
        .en       (!reset),
        .reg_w    ((state == ALUWB) | (state == MEMWB) | (state == LINK)),
        .dp       (state == ALUWB),
        .mem_w    (state == MEMWR),
        .branch   (state == BRANCH),
        .next_pc  ((state == FETCH) & mem_ready),
        .cond_ex  (CondEx),
        .no_write (NoWrite),
        .wa       (link_o ? LINK_REG : Rd),
        .pc_write (PCWrite),
        .reg_write(RegWrite),
        .mem_write(MemWrite)
    );
endmodule
